// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate generator for the decode stage.
// Decodes the immediate format from the opcode and extends it to DATA_WIDTH.
// The result sits in an output register. With SKID=1 a second entry absorbs
// the one instruction that is accepted while the consumer stalls.
module imm_ext_pipe #(
    parameter int DATA_WIDTH = 32,  // 32 or 64
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ImmExt,
    output logic [2:0]            ImmFmt,
    output logic                  imm_illegal
);

    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_S    = 3'b001;
    localparam logic [2:0] FMT_B    = 3'b010;
    localparam logic [2:0] FMT_U    = 3'b011;
    localparam logic [2:0] FMT_J    = 3'b100;
    localparam logic [2:0] FMT_Z    = 3'b101;
    localparam logic [2:0] FMT_SH   = 3'b110;
    localparam logic [2:0] FMT_NONE = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  sh6;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [2:0]            dec_fmt;
    logic                  dec_ill;

    // Output register and skid entry; ready_q doubles as "out of reset" for SKID=0.
    logic                  out_valid_q, out_valid_n;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_n;
    logic [2:0]            out_fmt_q, out_fmt_n;
    logic                  out_ill_q, out_ill_n;
    logic                  skid_valid_q, skid_valid_n;
    logic [DATA_WIDTH-1:0] skid_imm_q, skid_imm_n;
    logic [2:0]            skid_fmt_q, skid_fmt_n;
    logic                  skid_ill_q, skid_ill_n;
    logic                  ready_q, ready_n;
    logic                  accept;
    logic                  out_free;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    // Only RV64 OP-IMM shifts carry a 6-bit shamt; the W forms keep 5 bits.
    assign sh6    = (DATA_WIDTH == 64) && (opcode == OP_IMM);

    // Format selection from the opcode (and funct3 where the opcode is shared).
    always_comb begin
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: dec_fmt = FMT_I;
            OP_IMM: dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
            OP_IMM32: begin
                if (DATA_WIDTH == 64) begin
                    dec_fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_STORE:          dec_fmt = FMT_S;
            OP_BRANCH:         dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC:  dec_fmt = FMT_U;
            OP_JAL:            dec_fmt = FMT_J;
            OP_REG, OP_FENCE:  dec_fmt = FMT_NONE;
            OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    dec_fmt = FMT_NONE;
                end else if (funct3[2]) begin
                    dec_fmt = FMT_Z;
                end else begin
                    dec_fmt = FMT_I;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Immediate assembly: fill with the sign bit, then overwrite the low field.
    always_comb begin
        dec_imm = {DATA_WIDTH{instr[31]}};
        case (dec_fmt)
            FMT_I: dec_imm[11:0] = instr[31:20];
            FMT_S: dec_imm[11:0] = {instr[31:25], instr[11:7]};
            FMT_B: dec_imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: dec_imm[31:0] = {instr[31:12], 12'h000};
            FMT_J: dec_imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: begin
                dec_imm      = '0;
                dec_imm[4:0] = instr[19:15];
            end
            FMT_SH: begin
                dec_imm      = '0;
                dec_imm[4:0] = instr[24:20];
                if (sh6) begin
                    dec_imm[5] = instr[25];
                end
            end
            default: dec_imm = '0;
        endcase
    end

    // SKID=1 exposes the registered "skid empty" flag; SKID=0 the classic pipe ready.
    always_comb begin
        if (SKID) begin
            in_ready = ready_q;
        end else begin
            in_ready = ready_q & (~out_valid_q | out_ready);
        end
    end

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid_q | out_ready;

    // Next-state: refill output from skid first (ordering), else from input;
    // an accept during a stall parks in the skid entry. Flush overrides all.
    always_comb begin
        out_valid_n  = out_valid_q;
        out_imm_n    = out_imm_q;
        out_fmt_n    = out_fmt_q;
        out_ill_n    = out_ill_q;
        skid_valid_n = skid_valid_q;
        skid_imm_n   = skid_imm_q;
        skid_fmt_n   = skid_fmt_q;
        skid_ill_n   = skid_ill_q;
        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_n  = 1'b1;
                out_imm_n    = skid_imm_q;
                out_fmt_n    = skid_fmt_q;
                out_ill_n    = skid_ill_q;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_imm_n   = dec_imm;
                out_fmt_n   = dec_fmt;
                out_ill_n   = dec_ill;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_imm_n   = dec_imm;
            skid_fmt_n   = dec_fmt;
            skid_ill_n   = dec_ill;
        end
        ready_n = ~skid_valid_n;
    end

    // State registers with asynchronous clear to the reset output values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_ill_q   <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_n;
            out_imm_q    <= out_imm_n;
            out_fmt_q    <= out_fmt_n;
            out_ill_q    <= out_ill_n;
            skid_valid_q <= skid_valid_n;
            skid_imm_q   <= skid_imm_n;
            skid_fmt_q   <= skid_fmt_n;
            skid_ill_q   <= skid_ill_n;
            ready_q      <= ready_n;
        end
    end

    assign out_valid   = out_valid_q;
    assign ImmExt      = out_imm_q;
    assign ImmFmt      = out_fmt_q;
    assign imm_illegal = out_ill_q;

endmodule
